// File: rtl/dbg_halt_ctrl_pkg.sv
// Shared types and constants for the debug halt/resume sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: dbg_state_e FSM encoding, default debug-ROM window matching the
// SoC memory map, and a small max helper for counter sizing.
package dbg_ctrl_pkg;

   typedef enum logic [2:0] {
      BOOT,
      RUN,
      REQ,
      HALTED,
      RESUME
   } dbg_state_e;

   // Debug-ROM window as placed in the SoC memory map.
   localparam logic [31:0] DM_BASE_DEFAULT = 32'h1A11_0800;
   localparam logic [31:0] DM_SIZE_DEFAULT = 32'h0000_0800;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/dbg_halt_ctrl_if.sv
// Bundle of host commands, core fetch-address feedback and core control lines.
// Latency: n/a (wires only).
// Backpressure: none; commands are level-sampled every cycle.
// Modports: slave  = the sequencer (takes commands + fetch address, drives core controls)
//           master = host/SoC side (drives commands + fetch address, observes status)
interface dbg_halt_ctrl_if;

   logic        halt_req_i;
   logic        resume_req_i;
   logic        clear_err_i;
   logic [31:0] core_instr_addr_i;
   logic        fetch_enable_o;
   logic        debug_req_o;
   logic        resume_o;
   logic        halted_o;
   logic        timeout_o;

   modport slave (
      input  halt_req_i,
      input  resume_req_i,
      input  clear_err_i,
      input  core_instr_addr_i,
      output fetch_enable_o,
      output debug_req_o,
      output resume_o,
      output halted_o,
      output timeout_o
   );

   modport master (
      output halt_req_i,
      output resume_req_i,
      output clear_err_i,
      output core_instr_addr_i,
      input  fetch_enable_o,
      input  debug_req_o,
      input  resume_o,
      input  halted_o,
      input  timeout_o
   );

endinterface

// File: rtl/dbg_halt_ctrl_addr_window_cmp.sv
// Address-window decode: flags addr_i inside [BASE, BASE+SIZE), unsigned.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: addr_i (address under test), in_win_o (1 when inside the window).
module addr_window_cmp #(
   parameter int unsigned           ADDR_W = 32,
   parameter logic [ADDR_W-1:0]     BASE   = '0,
   parameter logic [ADDR_W-1:0]     SIZE   = '0
) (
   input  logic [ADDR_W-1:0] addr_i,
   output logic              in_win_o
);

   // One extra bit so a window ending exactly at the top of the address
   // space still compares correctly.
   localparam logic [ADDR_W:0] LIMIT = {1'b0, BASE} + {1'b0, SIZE};

   assign in_win_o = (addr_i >= BASE) && ({1'b0, addr_i} < LIMIT);

endmodule

// File: rtl/dbg_halt_ctrl.sv
// Debug-request sequencer: boot fetch delay, held halt/resume requests, ROM-window confirmation, timeout.
// Latency: all outputs registered; a command sampled at edge N is visible after edge N.
// Backpressure: none; commands are level-sampled and ignored in states that cannot accept them.
// Ports: clk_i, rst_ni (async active-low); bus (slave modport) carries host commands,
//        core fetch address, and fetch_enable/debug_req/resume/halted/timeout outputs.
module dbg_halt_ctrl
   import dbg_ctrl_pkg::*;
#(
   parameter int unsigned BOOT_CYCLES = 4,
   parameter int unsigned TIMEOUT     = 16,
   parameter logic [31:0] DM_BASE     = DM_BASE_DEFAULT,
   parameter logic [31:0] DM_SIZE     = DM_SIZE_DEFAULT
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   dbg_halt_ctrl_if.slave bus
);

   localparam int unsigned      CNT_W     = $clog2(max_u(BOOT_CYCLES, TIMEOUT) + 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);

   dbg_state_e       state_q,     state_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic             fetch_en_q,  fetch_en_d;
   logic             debug_req_q, debug_req_d;
   logic             resume_q,    resume_d;
   logic             halted_q,    halted_d;
   logic             timeout_q,   timeout_d;

   logic             in_rom;
   logic             tmo_set;
   logic [CNT_W-1:0] cnt_inc;

   addr_window_cmp #(
      .ADDR_W (32),
      .BASE   (DM_BASE),
      .SIZE   (DM_SIZE)
   ) u_rom_win (
      .addr_i   (bus.core_instr_addr_i),
      .in_win_o (in_rom)
   );

   // State and output registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= BOOT;
         cnt_q       <= '0;
         fetch_en_q  <= 1'b0;
         debug_req_q <= 1'b0;
         resume_q    <= 1'b0;
         halted_q    <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         fetch_en_q  <= fetch_en_d;
         debug_req_q <= debug_req_d;
         resume_q    <= resume_d;
         halted_q    <= halted_d;
         timeout_q   <= timeout_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      fetch_en_d  = fetch_en_q;
      debug_req_d = debug_req_q;
      resume_d    = resume_q;
      halted_d    = halted_q;
      tmo_set     = 1'b0;
      // Saturating increment: the counter never wraps back to zero.
      cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

      unique case (state_q)
         BOOT: begin
            cnt_d = cnt_inc;
            if (cnt_q == BOOT_LAST) begin
               state_d    = RUN;
               fetch_en_d = 1'b1;
            end
         end
         RUN: begin
            // Host halt takes priority over an ebreak that lands in the ROM.
            if (bus.halt_req_i) begin
               state_d     = REQ;
               debug_req_d = 1'b1;
               cnt_d       = '0;
            end else if (in_rom) begin
               state_d  = HALTED;
               halted_d = 1'b1;
            end
         end
         REQ: begin
            if (in_rom) begin
               state_d     = HALTED;
               debug_req_d = 1'b0;
               halted_d    = 1'b1;
            end else if (cnt_q == TMO_LAST) begin
               state_d     = RUN;
               debug_req_d = 1'b0;
               tmo_set     = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         HALTED: begin
            if (bus.resume_req_i) begin
               state_d  = RESUME;
               resume_d = 1'b1;
               cnt_d    = '0;
            end
         end
         RESUME: begin
            if (!in_rom) begin
               state_d  = RUN;
               resume_d = 1'b0;
               halted_d = 1'b0;
            end else if (cnt_q == TMO_LAST) begin
               // Core never left the ROM: it is still halted.
               state_d  = HALTED;
               resume_d = 1'b0;
               tmo_set  = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase

      // A fresh timeout event beats a simultaneous clear.
      timeout_d = tmo_set | (timeout_q & ~bus.clear_err_i);
   end

   // Outputs come straight from registers.
   assign bus.fetch_enable_o = fetch_en_q;
   assign bus.debug_req_o    = debug_req_q;
   assign bus.resume_o       = resume_q;
   assign bus.halted_o       = halted_q;
   assign bus.timeout_o      = timeout_q;

endmodule

// File: tb/tb_dbg_halt_ctrl.sv
// Self-checking bench for dbg_halt_ctrl: directed scenarios plus randomized traffic
// checked every cycle against a flag-based behavioural model.
module tb_dbg_halt_ctrl;

   localparam int unsigned BOOT_CYCLES = 4;
   localparam int unsigned TIMEOUT     = 16;
   localparam logic [31:0] ROM_BASE    = 32'h1A11_0800;
   localparam logic [31:0] ROM_SIZE    = 32'h0000_0800;

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b1;

   always #5 clk_i = ~clk_i;

   dbg_halt_ctrl_if bus ();

   dbg_halt_ctrl #(
      .BOOT_CYCLES (BOOT_CYCLES),
      .TIMEOUT     (TIMEOUT),
      .DM_BASE     (ROM_BASE),
      .DM_SIZE     (ROM_SIZE)
   ) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Tracks "boot edges seen", "request pending", "resume pending", "halted",
   // and how many edges the pending flag has been held.
   bit m_fetch  = 1'b0;
   bit m_dbg    = 1'b0;
   bit m_res    = 1'b0;
   bit m_halted = 1'b0;
   bit m_tmo    = 1'b0;
   int m_boot   = 0;
   int m_age    = 0;

   function automatic bit rom_hit(input logic [31:0] a);
      return (a >= ROM_BASE) && ((a - ROM_BASE) < ROM_SIZE);
   endfunction

   always @(posedge clk_i or negedge rst_ni) begin : model
      bit ev;
      bit rom;
      if (!rst_ni) begin
         m_fetch = 0; m_dbg = 0; m_res = 0; m_halted = 0; m_tmo = 0;
         m_boot  = 0; m_age = 0;
      end else begin
         ev  = 0;
         rom = rom_hit(bus.core_instr_addr_i);
         if (!m_fetch) begin
            m_boot++;
            if (m_boot == BOOT_CYCLES) m_fetch = 1;
         end else if (m_dbg) begin
            if (rom) begin
               m_dbg = 0; m_halted = 1;
            end else begin
               m_age++;
               if (m_age == TIMEOUT) begin m_dbg = 0; ev = 1; end
            end
         end else if (m_res) begin
            if (!rom) begin
               m_res = 0; m_halted = 0;
            end else begin
               m_age++;
               if (m_age == TIMEOUT) begin m_res = 0; ev = 1; end
            end
         end else if (m_halted) begin
            if (bus.resume_req_i) begin m_res = 1; m_age = 0; end
         end else begin
            if (bus.halt_req_i) begin m_dbg = 1; m_age = 0; end
            else if (rom) m_halted = 1;
         end
         m_tmo = ev | (m_tmo & ~bus.clear_err_i);
      end
   end

   // Every-cycle comparison, away from the active edge.
   always @(negedge clk_i) begin
      check("cyc_fetch_enable", {31'd0, bus.fetch_enable_o}, {31'd0, m_fetch});
      check("cyc_debug_req",    {31'd0, bus.debug_req_o},    {31'd0, m_dbg});
      check("cyc_resume",       {31'd0, bus.resume_o},       {31'd0, m_res});
      check("cyc_halted",       {31'd0, bus.halted_o},       {31'd0, m_halted});
      check("cyc_timeout",      {31'd0, bus.timeout_o},      {31'd0, m_tmo});
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_fetch"},  {31'd0, bus.fetch_enable_o}, 0);
      check({tag, "_dbg"},    {31'd0, bus.debug_req_o},    0);
      check({tag, "_resume"}, {31'd0, bus.resume_o},       0);
      check({tag, "_halted"}, {31'd0, bus.halted_o},       0);
      check({tag, "_tmo"},    {31'd0, bus.timeout_o},      0);
   endtask

   task automatic boot_check(input string tag);
      for (int i = 1; i <= 4; i++) begin
         tick();
         check({tag, "_fetch"}, {31'd0, bus.fetch_enable_o}, (i >= 4) ? 1 : 0);
         check({tag, "_dbg"},   {31'd0, bus.debug_req_o}, 0);
         check({tag, "_halt"},  {31'd0, bus.halted_o}, 0);
      end
   endtask

   function automatic logic [31:0] pick_addr();
      logic [31:0] a;
      case ($urandom_range(0, 5))
         0:       a = ROM_BASE;
         1:       a = ROM_BASE + ROM_SIZE - 32'd4;
         2:       a = ROM_BASE + ROM_SIZE;
         3:       a = ROM_BASE - 32'd1;
         4:       a = ROM_BASE + ($urandom_range(0, 511) << 2);
         default: a = 32'h0000_0080 + ($urandom_range(0, 63) << 2);
      endcase
      return a;
   endfunction

   initial begin
      int n;
      bus.halt_req_i        = 1'b0;
      bus.resume_req_i      = 1'b0;
      bus.clear_err_i       = 1'b0;
      bus.core_instr_addr_i = 32'h0000_0080;
      #1 rst_ni = 1'b0;
      #1 check_all_zero("reset");
      tick();
      tick();
      rst_ni = 1'b1;

      // Boot: fetch rises at the 4th edge after release.
      boot_check("boot");

      // Halt confirmed after six cycles of held request.
      bus.halt_req_i = 1'b1;
      tick();
      bus.halt_req_i = 1'b0;
      n = 0;
      for (int k = 0; k < 10; k++) begin
         n += int'(bus.debug_req_o);
         if (k == 5) bus.core_instr_addr_i = 32'h1A11_0800;
         tick();
      end
      check("halt_req_cycles", n, 6);
      check("halt_halted", {31'd0, bus.halted_o}, 1);
      check("halt_tmo", {31'd0, bus.timeout_o}, 0);

      // Resume: core leaves the ROM three cycles after the command.
      bus.resume_req_i = 1'b1;
      tick();
      bus.resume_req_i = 1'b0;
      n = 0;
      for (int k = 0; k < 8; k++) begin
         n += int'(bus.resume_o);
         if (k == 3) bus.core_instr_addr_i = 32'h0000_0084;
         tick();
      end
      check("resume_cycles", n, 4);
      check("resume_halted", {31'd0, bus.halted_o}, 0);

      // Halt timeout: core never enters the ROM.
      bus.core_instr_addr_i = 32'h0000_0080;
      bus.halt_req_i = 1'b1;
      tick();
      bus.halt_req_i = 1'b0;
      n = 0;
      for (int k = 0; k < 24; k++) begin
         n += int'(bus.debug_req_o);
         tick();
      end
      check("tmo_req_cycles", n, 16);
      check("tmo_flag", {31'd0, bus.timeout_o}, 1);
      check("tmo_not_halted", {31'd0, bus.halted_o}, 0);
      bus.clear_err_i = 1'b1;
      tick();
      bus.clear_err_i = 1'b0;
      check("tmo_cleared", {31'd0, bus.timeout_o}, 0);

      // Ebreak self-entry at the last ROM word.
      bus.core_instr_addr_i = 32'h1A11_0FFC;
      tick();
      check("ebreak_halted", {31'd0, bus.halted_o}, 1);
      n = 0;
      for (int k = 0; k < 4; k++) begin
         n += int'(bus.debug_req_o);
         tick();
      end
      check("ebreak_no_req", n, 0);
      bus.resume_req_i = 1'b1;
      tick();
      bus.resume_req_i = 1'b0;
      check("ebreak_resume", {31'd0, bus.resume_o}, 1);
      // First byte past the window counts as outside.
      bus.core_instr_addr_i = 32'h1A11_1000;
      tick();
      check("past_end_resume", {31'd0, bus.resume_o}, 0);
      check("past_end_halted", {31'd0, bus.halted_o}, 0);
      bus.core_instr_addr_i = 32'h1A11_07FF;
      tick();
      check("below_base_halted", {31'd0, bus.halted_o}, 0);

      // Halt and resume together in RUN: halt wins.
      bus.core_instr_addr_i = 32'h0000_0080;
      bus.halt_req_i   = 1'b1;
      bus.resume_req_i = 1'b1;
      tick();
      bus.halt_req_i   = 1'b0;
      bus.resume_req_i = 1'b0;
      check("both_dbg", {31'd0, bus.debug_req_o}, 1);
      check("both_resume", {31'd0, bus.resume_o}, 0);
      tick();

      // Asynchronous reset in REQ, then the boot delay repeats.
      #2 rst_ni = 1'b0;
      #1 check_all_zero("async_rst");
      tick();
      rst_ni = 1'b1;
      boot_check("reboot");

      // Randomized traffic, checked by the model every cycle.
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 7) == 0) bus.core_instr_addr_i = pick_addr();
         bus.halt_req_i   = ($urandom_range(0, 7) == 0);
         bus.resume_req_i = ($urandom_range(0, 7) == 0);
         bus.clear_err_i  = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 599) == 0) begin
            rst_ni = 1'b0;
            tick();
            rst_ni = 1'b1;
         end
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dbg_halt_ctrl.md
# dbg_halt_ctrl

Debug-request sequencer between the debug host and the core's `debug_req_i` / `fetch_enable_i` inputs inside `soc`. After reset it holds the core's fetch for a programmable boot delay. It then converts single-cycle halt and resume commands into properly held debug requests and resume flags. Debug-mode entry and exit are confirmed by watching the core's instruction-fetch address enter or leave the debug-ROM window, and a bounded wait guards against a core that never responds.

## Interface

Parameters:

- `BOOT_CYCLES`, default 4: cycles after reset release before `fetch_enable_o` rises. Must be ≥1.
- `TIMEOUT`, default 16: maximum cycles to wait for debug-mode entry or exit. Must be ≥1.
- `DM_BASE`, default 32'h1A11_0800: first byte address of the debug-ROM window.
- `DM_SIZE`, default 32'h0000_0800: window size in bytes. `DM_BASE+DM_SIZE` must not overflow 32 bits.

Ports:

- `clk_i`, input, 1: clock. All state updates on the rising edge.
- `rst_ni`, input, 1: reset, asynchronous, active-low.
- `halt_req_i`, input, 1: host halt command, sampled every cycle.
- `resume_req_i`, input, 1: host resume command, sampled every cycle.
- `clear_err_i`, input, 1: clears `timeout_o`.
- `core_instr_addr_i`, input, 32: core instruction-fetch address (`instr_addr_o` of the core).
- `fetch_enable_o`, output, 1: drives the core's `fetch_enable_i`.
- `debug_req_o`, output, 1: drives the core's `debug_req_i`.
- `resume_o`, output, 1: resume flag polled by the debug-ROM code.
- `halted_o`, output, 1: core is confirmed in debug mode.
- `timeout_o`, output, 1: sticky flag, entry or exit not confirmed within `TIMEOUT`.

## Operation

- `in_rom` is a combinational signal: `DM_BASE ≤ core_instr_addr_i < DM_BASE+DM_SIZE`, 32-bit unsigned compare.
- States: BOOT, RUN, REQ, HALTED, RESUME.
- Reset values: state BOOT, counter 0, and every output 0.
- BOOT:
  - Counter increments each cycle.
  - When counter == `BOOT_CYCLES-1`, go to RUN and set `fetch_enable_o`=1.
  - `fetch_enable_o` then stays 1 until the next reset. Host commands are ignored in BOOT.
- RUN:
  - `halt_req_i`=1 → REQ, `debug_req_o`=1, counter cleared.
  - Otherwise, `in_rom`=1 (self-entry via ebreak) → HALTED, `halted_o`=1.
  - `resume_req_i` is ignored in RUN. If halt and resume arrive in the same cycle, halt wins.
- REQ:
  - `debug_req_o` is held at 1.
  - `in_rom`=1 → HALTED, `debug_req_o`=0, `halted_o`=1.
  - Otherwise counter increments. When counter == `TIMEOUT-1` → RUN, `debug_req_o`=0, `timeout_o`=1.
  - Further `halt_req_i` pulses are ignored.
- HALTED:
  - `resume_req_i`=1 → RESUME, `resume_o`=1, counter cleared.
  - `halt_req_i` is ignored.
- RESUME:
  - `resume_o` is held at 1.
  - `in_rom`=0 → RUN, `resume_o`=0, `halted_o`=0.
  - Otherwise counter increments. When counter == `TIMEOUT-1` → HALTED, `resume_o`=0, `timeout_o`=1; `halted_o` stays 1.
- `timeout_o`:
  - Cleared by `clear_err_i`.
  - If a set event and `clear_err_i` occur in the same cycle, the set wins.
- Reset asserted mid-operation returns immediately (asynchronously) to the reset values. `fetch_enable_o` drops and the boot delay restarts.
- The counter is `$clog2(max(BOOT_CYCLES,TIMEOUT)+1)` bits wide, saturates, and never wraps.

## Timing

- All outputs are registered, with no combinational input-to-output path.
- `fetch_enable_o` rises at the `BOOT_CYCLES`-th rising edge after reset deassertion.
- Halt latency: `halt_req_i` high at edge N gives `debug_req_o`=1 after edge N.
- Entry confirmation: `in_rom` high at edge M gives `debug_req_o`=0 and `halted_o`=1 after edge M.
- Resume latency: `resume_req_i` at edge N gives `resume_o`=1 after edge N.
- Exit confirmation: `in_rom` low at edge M gives `resume_o`=0 and `halted_o`=0 after edge M.
- Request or resume flag is held for at most `TIMEOUT` cycles.
- Host commands are level-sampled. A command held high across a state transition takes effect only in a state that accepts it. Example: a `halt_req_i` still high on re-entering RUN issues a new halt.

## Structure

- `dbg_ctrl_pkg` holds:
  - the `dbg_state_e` enum (BOOT, RUN, REQ, HALTED, RESUME);
  - the default `DM_BASE` / `DM_SIZE` constants shared with the SoC memory map.
- One sub-module, `addr_window_cmp`: a parameterised base/size range check producing `in_rom`. It is reusable for other address-window decodes.
- The FSM, counter and output registers live in a single `always_ff` with an async reset, plus one `always_comb` for next-state logic.

## Test plan

Defaults for all scenarios: `BOOT_CYCLES`=4, `TIMEOUT`=16, `DM_BASE`=0x1A110800, `DM_SIZE`=0x800.

1. Boot: release reset, all inputs 0 → `fetch_enable_o`=0 for 3 edges and 1 from the 4th edge onward. All other outputs stay 0.
2. Halt: pulse `halt_req_i` in RUN, then drive the address to 0x1A110800 five cycles later → `debug_req_o` high for exactly 6 cycles, then `halted_o`=1 and `timeout_o`=0.
3. Halt timeout: pulse `halt_req_i` and keep the address at 0x00000080 → `debug_req_o` high for 16 cycles, then `timeout_o`=1 and state RUN. Pulse `clear_err_i` → `timeout_o`=0.
4. Resume: from HALTED, pulse `resume_req_i`, then change the address to 0x00000084 three cycles later → `resume_o` high for 4 cycles, then `halted_o`=0.
5. Ebreak self-entry and address boundaries:
   - In RUN with no request, address goes to 0x1A110FFC → `halted_o`=1 and `debug_req_o` never asserts.
   - Address 0x1A111000 (first byte past the window) is not treated as in-ROM.
6. Corner cases:
   - `halt_req_i` and `resume_req_i` high in the same cycle in RUN → state REQ, `resume_o`=0.
   - Assert `rst_ni` low while in REQ → all outputs 0 asynchronously, and boot repeats.
